// File: rtl/muldiv_pkg.sv
// rtl/muldiv_pkg.sv - shared state encoding, function codes and default width for the mul/div sequencer
package muldiv_pkg;

    localparam int DEFAULT_WIDTH = 16;

    localparam logic [3:0] FN_MUL = 4'b0100;
    localparam logic [3:0] FN_DIV = 4'b1000;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_SIGN = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    function automatic logic is_muldiv(input logic [3:0] func);
        return (func == FN_MUL) || (func == FN_DIV);
    endfunction

endpackage

// File: rtl/muldiv_step.sv
// rtl/muldiv_step.sv - one unsigned shift-add multiply or restoring divide iteration
//
// Ports:
//   is_div   selects the divide iteration, otherwise multiply
//   hi_in    multiply: partial product high half; divide: partial remainder
//   lo_in    multiply: remaining multiplier bits; divide: dividend bits / quotient
//   operand  multiply: multiplicand magnitude; divide: divisor magnitude
//   hi_out   updated high register
//   lo_out   updated low register
module muldiv_step #(
    parameter int WIDTH = 16
) (
    input  logic             is_div,
    input  logic [WIDTH-1:0] hi_in,
    input  logic [WIDTH-1:0] lo_in,
    input  logic [WIDTH-1:0] operand,
    output logic [WIDTH-1:0] hi_out,
    output logic [WIDTH-1:0] lo_out
);

    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_shift;
    logic [WIDTH-1:0] div_diff;
    logic             div_ge;

    // Multiply: add the multiplicand when the current multiplier bit is set,
    // then shift the whole {carry, hi, lo} right so the product grows in hi
    // while consumed multiplier bits fall out of lo.
    assign mul_sum = {1'b0, hi_in} + (lo_in[0] ? {1'b0, operand} : '0);

    // Divide: bring the next dividend bit into the remainder; the quotient
    // bit enters lo from the right as the dividend bits leave on the left.
    // When the subtraction is kept the true difference is below the divisor,
    // so its low WIDTH bits are exact.
    assign div_shift = {hi_in, lo_in[WIDTH-1]};
    assign div_ge    = div_shift >= {1'b0, operand};
    assign div_diff  = div_shift[WIDTH-1:0] - operand;

    always_comb begin
        hi_out = mul_sum[WIDTH:1];
        lo_out = {mul_sum[0], lo_in[WIDTH-1:1]};
        if (is_div) begin
            hi_out = div_ge ? div_diff : div_shift[WIDTH-1:0];
            lo_out = {lo_in[WIDTH-2:0], div_ge};
        end
    end

endmodule

// File: rtl/muldiv_sequencer.sv
// rtl/muldiv_sequencer.sv - multi-cycle signed multiply/divide unit that stalls the pipeline while it iterates
//
// Ports:
//   clk, reset          rising-edge clock, asynchronous active-high reset
//   start, func         issue request and function code (FN_MUL / FN_DIV)
//   op_a, op_b          two's complement operands
//   flush               abort; returns to idle at the next edge, no done
//   busy                iterating or fixing signs
//   stall               busy, or an operation is being accepted this cycle
//   done                one-cycle pulse, results valid in that cycle
//   result_lo/hi        product low/high or quotient/remainder; held until replaced
//   div_by_zero         exception pulse with done
//   overflow            exception pulse with done (most-negative / -1)
module muldiv_sequencer
    import muldiv_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       func,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             flush,
    output logic             busy,
    output logic             stall,
    output logic             done,
    output logic [WIDTH-1:0] result_lo,
    output logic [WIDTH-1:0] result_hi,
    output logic             div_by_zero,
    output logic             overflow
);

    localparam int               CW       = $clog2(WIDTH + 1);
    localparam logic [CW-1:0]    LAST     = CW'(WIDTH - 1);
    localparam logic [WIDTH-1:0] ALL_ONES = '1;
    localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    state_t           state;
    logic [CW-1:0]    count;
    logic             is_div;
    logic             neg_res;
    logic             neg_rem;
    logic [WIDTH-1:0] operand;
    logic [WIDTH-1:0] acc_hi;
    logic [WIDTH-1:0] acc_lo;
    logic [WIDTH-1:0] step_hi;
    logic [WIDTH-1:0] step_lo;
    logic [WIDTH-1:0] sign_hi;
    logic [WIDTH-1:0] sign_lo;

    logic             accept;
    logic             a_neg;
    logic             b_neg;
    logic [WIDTH-1:0] abs_a;
    logic [WIDTH-1:0] abs_b;
    logic             req_div;

    assign req_div = (func == FN_DIV);
    assign a_neg   = op_a[WIDTH-1];
    assign b_neg   = op_b[WIDTH-1];
    // The magnitude of the most-negative value is 2^(WIDTH-1), which still
    // fits as an unsigned WIDTH-bit number, so no extra bit is needed.
    assign abs_a   = a_neg ? -op_a : op_a;
    assign abs_b   = b_neg ? -op_b : op_b;

    // Flush beats start; reset is folded in so stall cannot leak high while
    // reset is held with start asserted.
    assign accept = !reset && (state == ST_IDLE) && start && is_muldiv(func) && !flush;
    assign stall  = busy || accept;

    muldiv_step #(
        .WIDTH(WIDTH)
    ) u_step (
        .is_div  (is_div),
        .hi_in   (acc_hi),
        .lo_in   (acc_lo),
        .operand (operand),
        .hi_out  (step_hi),
        .lo_out  (step_lo)
    );

    // Sign fix-up of the unsigned magnitudes; the remainder follows the
    // dividend so the quotient truncates toward zero.
    always_comb begin
        sign_hi = acc_hi;
        sign_lo = acc_lo;
        if (is_div) begin
            if (neg_res) sign_lo = -acc_lo;
            if (neg_rem) sign_hi = -acc_hi;
        end else if (neg_res) begin
            {sign_hi, sign_lo} = -{acc_hi, acc_lo};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= ST_IDLE;
            count       <= '0;
            is_div      <= 1'b0;
            neg_res     <= 1'b0;
            neg_rem     <= 1'b0;
            operand     <= '0;
            acc_hi      <= '0;
            acc_lo      <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
            overflow    <= 1'b0;
            result_lo   <= '0;
            result_hi   <= '0;
        end else begin
            done        <= 1'b0;
            div_by_zero <= 1'b0;
            overflow    <= 1'b0;
            if (flush) begin
                state <= ST_IDLE;
                count <= '0;
                busy  <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (accept) begin
                            count   <= '0;
                            is_div  <= req_div;
                            neg_res <= a_neg ^ b_neg;
                            neg_rem <= a_neg;
                            acc_hi  <= '0;
                            if (req_div && (op_b == '0)) begin
                                result_lo   <= ALL_ONES;
                                result_hi   <= op_a;
                                div_by_zero <= 1'b1;
                                done        <= 1'b1;
                                state       <= ST_DONE;
                            end else if (req_div && (op_a == MOST_NEG) && (op_b == ALL_ONES)) begin
                                result_lo <= op_a;
                                result_hi <= '0;
                                overflow  <= 1'b1;
                                done      <= 1'b1;
                                state     <= ST_DONE;
                            end else begin
                                // Divide walks the dividend through lo; multiply
                                // walks the multiplier through lo.
                                acc_lo  <= req_div ? abs_a : abs_b;
                                operand <= req_div ? abs_b : abs_a;
                                busy    <= 1'b1;
                                state   <= ST_CALC;
                            end
                        end
                    end
                    ST_CALC: begin
                        acc_hi <= step_hi;
                        acc_lo <= step_lo;
                        if (count == LAST) begin
                            count <= '0;
                            state <= ST_SIGN;
                        end else begin
                            count <= count + 1'b1;
                        end
                    end
                    ST_SIGN: begin
                        result_lo <= sign_lo;
                        result_hi <= sign_hi;
                        done      <= 1'b1;
                        busy      <= 1'b0;
                        state     <= ST_DONE;
                    end
                    ST_DONE: begin
                        state <= ST_IDLE;
                    end
                    default: begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// tb/tb_muldiv_sequencer.sv - self-checking bench for muldiv_sequencer
module tb_muldiv_sequencer;
    import muldiv_pkg::*;

    localparam int W = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [3:0]    func;
    logic [W-1:0]  op_a;
    logic [W-1:0]  op_b;
    logic          flush;
    logic          busy;
    logic          stall;
    logic          done;
    logic [W-1:0]  result_lo;
    logic [W-1:0]  result_hi;
    logic          div_by_zero;
    logic          overflow;

    int checks   = 0;
    int failures = 0;
    int done_cnt = 0;
    bit chk_en   = 1'b0;

    always #5 clk = ~clk;

    muldiv_sequencer #(.WIDTH(W)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .func        (func),
        .op_a        (op_a),
        .op_b        (op_b),
        .flush       (flush),
        .busy        (busy),
        .stall       (stall),
        .done        (done),
        .result_lo   (result_lo),
        .result_hi   (result_hi),
        .div_by_zero (div_by_zero),
        .overflow    (overflow)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference arithmetic: {overflow, div_by_zero, hi, lo}
    function automatic logic [33:0] golden(input logic [3:0] f, input logic [15:0] a, input logic [15:0] b);
        int sa, sb, p, q, r;
        sa = int'($signed(a));
        sb = int'($signed(b));
        if (f == FN_MUL) begin
            p = sa * sb;
            return {2'b00, 32'(p)};
        end
        if (b == 16'h0000) return {2'b01, a, 16'hFFFF};
        if (a == 16'h8000 && b == 16'hFFFF) return {2'b10, 16'h0000, a};
        q = sa / sb;
        r = sa % sb;
        return {2'b00, 16'(r), 16'(q)};
    endfunction

    function automatic int latency(input logic [3:0] f, input logic [15:0] a, input logic [15:0] b);
        if (f == FN_DIV && (b == 16'h0000 || (a == 16'h8000 && b == 16'hFFFF))) return 1;
        return W + 2;
    endfunction

    // Behavioural model: age counts cycles since the accepting edge.
    bit          m_active;
    int          m_age;
    int          m_lat;
    logic [33:0] m_res;
    logic [15:0] m_lo;
    logic [15:0] m_hi;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_active <= 1'b0;
            m_age    <= 0;
            m_lat    <= 0;
            m_res    <= '0;
            m_lo     <= '0;
            m_hi     <= '0;
        end else if (flush) begin
            m_active <= 1'b0;
        end else if (!m_active) begin
            if (start && is_muldiv(func)) begin
                m_active <= 1'b1;
                m_age    <= 1;
                m_lat    <= latency(func, op_a, op_b);
                m_res    <= golden(func, op_a, op_b);
                if (latency(func, op_a, op_b) == 1) begin
                    m_lo <= golden(func, op_a, op_b) >> 0;
                    m_hi <= golden(func, op_a, op_b) >> 16;
                end
            end
        end else if (m_age == m_lat) begin
            m_active <= 1'b0;
        end else begin
            m_age <= m_age + 1;
            if (m_age + 1 == m_lat) begin
                m_lo <= m_res[15:0];
                m_hi <= m_res[31:16];
            end
        end
    end

    always @(negedge clk) begin
        if (done === 1'b1) done_cnt++;
        if (chk_en) begin
            chk("cyc_done",  done,        m_active && m_age == m_lat);
            chk("cyc_dz",    div_by_zero, m_active && m_age == m_lat && m_res[32]);
            chk("cyc_ovf",   overflow,    m_active && m_age == m_lat && m_res[33]);
            chk("cyc_busy",  busy,        m_active && m_age < m_lat);
            chk("cyc_stall", stall,       (m_active && m_age < m_lat) ||
                                          (!m_active && start && is_muldiv(func) && !flush && !reset));
            chk("cyc_lo",    result_lo,   m_lo);
            chk("cyc_hi",    result_hi,   m_hi);
        end
    end

    // Called at posedge+1 with the DUT idle; returns at posedge+1, idle again.
    task automatic run_op(input string nm, input logic [3:0] f, input logic [15:0] a, input logic [15:0] b,
                          input int exp_cyc, input logic [15:0] elo, input logic [15:0] ehi,
                          input logic edz, input logic eovf, input int restart_cyc);
        int cyc;
        int d0;
        d0    = done_cnt;
        start = 1'b1;
        func  = f;
        op_a  = a;
        op_b  = b;
        #1;
        chk({nm, "_stall0"}, stall, 1'b1);
        @(posedge clk); #1;
        start = 1'b0;
        cyc   = 1;
        while (done !== 1'b1 && cyc < 40) begin
            start = (cyc == restart_cyc);
            if (cyc == restart_cyc) begin
                func = FN_DIV;
                op_a = 16'h0064;
                op_b = 16'h0007;
            end
            @(posedge clk); #1;
            start = 1'b0;
            cyc++;
        end
        chk({nm, "_cycle"}, cyc, exp_cyc);
        chk({nm, "_lo"}, result_lo, elo);
        chk({nm, "_hi"}, result_hi, ehi);
        chk({nm, "_dz"}, div_by_zero, edz);
        chk({nm, "_ovf"}, overflow, eovf);
        chk({nm, "_stall_done"}, stall, 1'b0);
        @(posedge clk); #1;
        chk({nm, "_ndone"}, done_cnt - d0, 1);
    endtask

    initial begin
        int d0;
        reset = 1'b1;
        start = 1'b0;
        func  = 4'h0;
        op_a  = '0;
        op_b  = '0;
        flush = 1'b0;

        chk("gold_mul", golden(FN_MUL, 16'h0007, 16'hFFFD), 34'h0_FFFF_FFEB);
        chk("gold_div", golden(FN_DIV, 16'hFFF9, 16'h0002), 34'h0_FFFF_FFFD);
        chk("gold_dz",  golden(FN_DIV, 16'h0064, 16'h0000), 34'h1_0064_FFFF);
        chk("gold_ovf", golden(FN_DIV, 16'h8000, 16'hFFFF), 34'h2_0000_8000);

        repeat (2) @(posedge clk);
        #1;
        chk_en = 1'b1;
        chk("rst_busy", busy, 1'b0);
        chk("rst_stall", stall, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_lo", result_lo, 16'h0000);
        chk("rst_hi", result_hi, 16'h0000);
        reset = 1'b0;

        // first start right after reset release
        run_op("mul_7_m3",   FN_MUL, 16'h0007, 16'hFFFD, 18, 16'hFFEB, 16'hFFFF, 1'b0, 1'b0, 0);
        run_op("div_m7_2",   FN_DIV, 16'hFFF9, 16'h0002, 18, 16'hFFFD, 16'hFFFF, 1'b0, 1'b0, 0);
        run_op("div_zero",   FN_DIV, 16'h0064, 16'h0000, 1,  16'hFFFF, 16'h0064, 1'b1, 1'b0, 0);
        run_op("div_ovf",    FN_DIV, 16'h8000, 16'hFFFF, 1,  16'h8000, 16'h0000, 1'b0, 1'b1, 0);
        run_op("mul_min2",   FN_MUL, 16'h8000, 16'h8000, 18, 16'h0000, 16'h4000, 1'b0, 1'b0, 0);
        run_op("mul_m1m1",   FN_MUL, 16'hFFFF, 16'hFFFF, 18, 16'h0001, 16'h0000, 1'b0, 1'b0, 0);
        run_op("div_7_m2",   FN_DIV, 16'h0007, 16'hFFFE, 18, 16'hFFFD, 16'h0001, 1'b0, 1'b0, 0);
        run_op("div_100_7",  FN_DIV, 16'h0064, 16'h0007, 18, 16'h000E, 16'h0002, 1'b0, 1'b0, 0);
        run_op("div_min_1",  FN_DIV, 16'h8000, 16'h0001, 18, 16'h8000, 16'h0000, 1'b0, 1'b0, 0);
        run_op("mul_max_min", FN_MUL, 16'h7FFF, 16'h8000, 18, 16'h8000, 16'hC000, 1'b0, 1'b0, 0);

        // flush in cycle 5 of a multiply
        d0    = done_cnt;
        start = 1'b1;
        func  = FN_MUL;
        op_a  = 16'h0003;
        op_b  = 16'h0004;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        chk("flush_busy", busy, 1'b0);
        chk("flush_stall", stall, 1'b0);
        repeat (22) @(posedge clk);
        #1;
        chk("flush_ndone", done_cnt - d0, 0);
        chk("flush_lo", result_lo, 16'h8000);
        chk("flush_hi", result_hi, 16'hC000);

        // second start in cycle 3 is ignored
        run_op("mul_restart", FN_MUL, 16'h0003, 16'h0005, 18, 16'h000F, 16'h0000, 1'b0, 1'b0, 3);

        // invalid function code
        d0    = done_cnt;
        start = 1'b1;
        func  = 4'b0001;
        #1;
        chk("inv_stall", stall, 1'b0);
        @(posedge clk); #1;
        start = 1'b0;
        chk("inv_busy", busy, 1'b0);

        // flush and start together
        start = 1'b1;
        func  = FN_MUL;
        flush = 1'b1;
        #1;
        chk("fs_stall", stall, 1'b0);
        @(posedge clk); #1;
        start = 1'b0;
        flush = 1'b0;
        chk("fs_busy", busy, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        chk("inv_fs_ndone", done_cnt - d0, 0);

        // reset in cycle 9 of a multiply
        d0    = done_cnt;
        start = 1'b1;
        func  = FN_MUL;
        op_a  = 16'h1234;
        op_b  = 16'h0005;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        chk("pre_rst_busy", busy, 1'b1);
        reset = 1'b1;
        #1;
        chk("mid_rst_busy", busy, 1'b0);
        chk("mid_rst_stall", stall, 1'b0);
        chk("mid_rst_done", done, 1'b0);
        chk("mid_rst_lo", result_lo, 16'h0000);
        chk("mid_rst_hi", result_hi, 16'h0000);
        chk("mid_rst_flags", {div_by_zero, overflow}, 2'b00);
        @(posedge clk); #1;
        reset = 1'b0;
        chk("rst_ndone", done_cnt - d0, 0);
        run_op("post_rst", FN_DIV, 16'hFFF9, 16'h0002, 18, 16'hFFFD, 16'hFFFF, 1'b0, 1'b0, 0);

        repeat (2) @(posedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
